// File: rtl/proc_ctrl_sequencer_if.sv
// Bus between the processor control sequencer and its datapath/host.
// The host drives Run/DIN/Gnz; the sequencer drives enables, selects and status.
interface proc_ctrl_sequencer_if #(
   parameter int CNT_W = 16
);
   logic             Run;
   logic [15:0]      DIN;
   logic             Gnz;
   logic             IRin;
   logic [7:0]       Rin;
   logic [7:0]       Rout;
   logic             DINout;
   logic             Gout;
   logic             Ain;
   logic             Gin;
   logic             AddSub;
   logic             Done;
   logic [1:0]       Tstep;
   logic [CNT_W-1:0] icount;

   modport master (
      output Run, DIN, Gnz,
      input  IRin, Rin, Rout, DINout, Gout, Ain, Gin, AddSub, Done, Tstep, icount
   );

   modport slave (
      input  Run, DIN, Gnz,
      output IRin, Rin, Rout, DINout, Gout, Ain, Gin, AddSub, Done, Tstep, icount
   );
endinterface

// File: rtl/proc_ctrl_sequencer.sv
// Multi-cycle T0..T3 control sequencer for the 8-register bus processor,
// with a wrapping retired-instruction counter.
module proc_ctrl_sequencer #(
   parameter int CNT_W = 16
) (
   input logic                 Clock,
   input logic                 Resetn,
   proc_ctrl_sequencer_if.slave bus
);

   // Handshake: Run is a request sampled only in T0 (fetch happens on that edge
   // via IRin); Done is a one-cycle completion pulse; Run is ignored in T1..T3.
   typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} state_t;

   state_t           state, next_state;
   logic [8:0]       ir;
   logic [CNT_W-1:0] count;

   logic [2:0] opcode, rx, ry;
   logic [7:0] x_oh, y_oh;
   logic       irin, dinout, gout, ain, gin, addsub, done;
   logic [7:0] rin, rout;
   logic       unused_din;

   assign opcode     = ir[8:6];
   assign rx         = ir[5:3];
   assign ry         = ir[2:0];
   assign x_oh       = 8'b1 << rx;
   assign y_oh       = 8'b1 << ry;
   assign unused_din = ^bus.DIN[15:9];

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state <= T0;
         ir    <= '0;
         count <= '0;
      end else begin
         state <= next_state;
         if (irin) ir <= bus.DIN[8:0];
         if (done) count <= count + CNT_W'(1);
      end
   end

   always_comb begin
      next_state = state;
      irin       = 1'b0;
      rin        = '0;
      rout       = '0;
      dinout     = 1'b0;
      gout       = 1'b0;
      ain        = 1'b0;
      gin        = 1'b0;
      addsub     = 1'b0;
      done       = 1'b0;
      case (state)
         T0: begin
            irin = bus.Run;
            if (bus.Run) next_state = T1;
         end
         T1: begin
            next_state = T0;
            case (opcode)
               3'b000: begin
                  rout = y_oh;
                  rin  = x_oh;
                  done = 1'b1;
               end
               3'b001: begin
                  dinout = 1'b1;
                  rin    = x_oh;
                  done   = 1'b1;
               end
               3'b010, 3'b011: begin
                  rout       = x_oh;
                  ain        = 1'b1;
                  next_state = T2;
               end
               3'b100: begin
                  // Not-taken mvnz still retires, just without the register move.
                  if (bus.Gnz) begin
                     rout = y_oh;
                     rin  = x_oh;
                  end
                  done = 1'b1;
               end
               default: done = 1'b1;
            endcase
         end
         T2: begin
            rout       = y_oh;
            gin        = 1'b1;
            addsub     = ir[6];
            next_state = T3;
         end
         T3: begin
            gout       = 1'b1;
            rin        = x_oh;
            done       = 1'b1;
            next_state = T0;
         end
      endcase
   end

   assign bus.IRin   = irin;
   assign bus.Rin    = rin;
   assign bus.Rout   = rout;
   assign bus.DINout = dinout;
   assign bus.Gout   = gout;
   assign bus.Ain    = ain;
   assign bus.Gin    = gin;
   assign bus.AddSub = addsub;
   assign bus.Done   = done;
   assign bus.Tstep  = state;
   assign bus.icount = count;

endmodule
